// File: rtl/gbf_req_arb.sv
// gbf_req_arb
// Refill-request arbiter between NUM_CH global-buffer SRAM banks and one
// shared DRAM fetch port. Tracks per-bank occupancy and words in flight,
// round-robin picks a hungry bank, and issues one BURST-word request per
// Req/Ack handshake. Flags full/empty and sticky overflow/underflow.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   Reset      : synchronous clear (same effect as rst_n)
//   CfgThr     : refill threshold (held static while Req=1)
//   EnWr/EnRd  : per-bank single-word write/read beats
//   Ack        : fetch port accepts the current request
//   Req/ReqCh  : registered request valid and requested bank
//   Occ        : per-bank occupancy, bank i at [i*OCC_W +: OCC_W]
//   Full/Empty : Occ==DEPTH / Occ==0 per bank
//   ErrOvf     : sticky, write dropped because bank full
//   ErrUdf     : sticky, read dropped because bank empty
module gbf_req_arb #(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DEPTH  = 128,
  parameter  int unsigned BURST  = 32,
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1),
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Reset,
  input  logic [OCC_W-1:0]          CfgThr,
  input  logic [NUM_CH-1:0]         EnWr,
  input  logic [NUM_CH-1:0]         EnRd,
  input  logic                      Ack,
  output logic                      Req,
  output logic [CH_W-1:0]           ReqCh,
  output logic [NUM_CH*OCC_W-1:0]   Occ,
  output logic [NUM_CH-1:0]         Full,
  output logic [NUM_CH-1:0]         Empty,
  output logic [NUM_CH-1:0]         ErrOvf,
  output logic [NUM_CH-1:0]         ErrUdf
);

  // Two spare bits: Occ+Pend+BURST can reach 3*DEPTH in corner cases.
  localparam int unsigned SUM_W = OCC_W + 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [CH_W-1:0]   req_ch_q, req_ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [OCC_W-1:0]  occ_q  [NUM_CH];
  logic [OCC_W-1:0]  pend_q [NUM_CH];
  logic [SUM_W-1:0]  sum_w  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, udf_q;
  logic [NUM_CH-1:0] full_w, empty_w, wa, ra, elig, grant;
  logic [CH_W:0]     idx;
  logic [CH_W-1:0]   sel;
  logic              found;

  // Per-bank status, accept flags, eligibility and grant
  always_comb begin
    full_w  = '0;
    empty_w = '0;
    wa      = '0;
    ra      = '0;
    elig    = '0;
    grant   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum_w[i]   = SUM_W'(occ_q[i]) + SUM_W'(pend_q[i]);
      full_w[i]  = (occ_q[i] == OCC_W'(DEPTH));
      empty_w[i] = (occ_q[i] == '0);
      // A full bank still takes a write when a read drains it the same cycle
      wa[i]      = EnWr[i] & (~full_w[i] | EnRd[i]);
      ra[i]      = EnRd[i] & ~empty_w[i];
      elig[i]    = (sum_w[i] <= SUM_W'(CfgThr)) &&
                   ((sum_w[i] + SUM_W'(BURST)) <= SUM_W'(DEPTH)) &&
                   !(req_q && (req_ch_q == CH_W'(i)));
      grant[i]   = (state_q == S_WAIT) && Ack && (req_ch_q == CH_W'(i));
    end
  end

  // Round-robin pick: first eligible bank at or after rr_q, wrapping
  always_comb begin
    idx   = '0;
    sel   = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_q} + (CH_W + 1)'(k);
      if (idx >= (CH_W + 1)'(NUM_CH)) begin
        idx = idx - (CH_W + 1)'(NUM_CH);
      end
      if (!found && elig[idx[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[CH_W-1:0];
      end
    end
  end

  // Request FSM next state
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    req_ch_d = req_ch_q;
    rr_d     = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_WAIT;
          req_d    = 1'b1;
          req_ch_d = sel;
        end
      end
      S_WAIT: begin
        if (Ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          rr_d    = (req_ch_q == CH_W'(NUM_CH - 1)) ? '0 : req_ch_q + CH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      req_ch_q <= '0;
      rr_q     <= '0;
      ovf_q    <= '0;
      udf_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        occ_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else if (Reset) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      req_ch_q <= '0;
      rr_q     <= '0;
      ovf_q    <= '0;
      udf_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        occ_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      req_ch_q <= req_ch_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_q | (EnWr & ~wa);
      udf_q    <= udf_q | (EnRd & ~ra);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        occ_q[i]  <= occ_q[i] + (wa[i] ? OCC_W'(1) : '0)
                              - (ra[i] ? OCC_W'(1) : '0);
        // Grant adds a burst; writes only retire in-flight words while any remain
        pend_q[i] <= pend_q[i] + (grant[i] ? OCC_W'(BURST) : '0)
                               - ((wa[i] && (pend_q[i] != '0)) ? OCC_W'(1) : '0);
      end
    end
  end

  always_comb begin
    Occ = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      Occ[i*OCC_W +: OCC_W] = occ_q[i];
    end
  end

  assign Req    = req_q;
  assign ReqCh  = req_ch_q;
  assign Full   = full_w;
  assign Empty  = empty_w;
  assign ErrOvf = ovf_q;
  assign ErrUdf = udf_q;

endmodule

// File: tb/tb_gbf_req_arb.sv
module tb_gbf_req_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Reset;
  logic [7:0]  CfgThr;
  logic [3:0]  EnWr;
  logic [3:0]  EnRd;
  logic        Ack;
  logic        Req;
  logic [1:0]  ReqCh;
  logic [31:0] Occ;
  logic [3:0]  Full;
  logic [3:0]  Empty;
  logic [3:0]  ErrOvf;
  logic [3:0]  ErrUdf;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned exp_q[$];

  gbf_req_arb #(.NUM_CH(4), .DEPTH(128), .BURST(32)) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .CfgThr(CfgThr),
    .EnWr(EnWr), .EnRd(EnRd), .Ack(Ack),
    .Req(Req), .ReqCh(ReqCh), .Occ(Occ), .Full(Full), .Empty(Empty),
    .ErrOvf(ErrOvf), .ErrUdf(ErrUdf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] occ_of(input int unsigned i);
    return Occ[i*8 +: 8];
  endfunction

  // Acknowledge the pending request, optionally retune the threshold in the
  // Req-low cycle, then wait (bounded) for the next request.
  task automatic grant_next(input logic [7:0] thr, output logic gap_low, output int cyc);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    gap_low = (Req === 1'b0);
    CfgThr = thr;
    cyc = 0;
    while (Req !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int unsigned e;
    rst_n = 1'b0; Reset = 1'b0; Ack = 1'b0; EnWr = '0; EnRd = '0; CfgThr = 8'd64;
    repeat (2) tick();
    n_chk++;
    if (Req !== 1'b0 || ReqCh !== 2'd0) begin
      n_fail++; $display("FAIL reset_req: Req=%b ReqCh=%0d, required Req=0 ReqCh=0", Req, ReqCh);
    end
    n_chk++;
    if (Empty !== 4'hF || Full !== 4'h0) begin
      n_fail++; $display("FAIL reset_flags: Empty=%h Full=%h, required Empty=f Full=0", Empty, Full);
    end
    n_chk++;
    if (Occ !== 32'd0 || ErrOvf !== 4'h0 || ErrUdf !== 4'h0) begin
      n_fail++; $display("FAIL reset_state: Occ=%h ErrOvf=%h ErrUdf=%h, required all 0", Occ, ErrOvf, ErrUdf);
    end
    rst_n = 1'b1;
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    n_chk++;
    if (Req !== 1'b1 || ReqCh !== 2'(e)) begin
      n_fail++; $display("FAIL first_req: Req=%b ReqCh=%0d, required Req=1 ReqCh=%0d", Req, ReqCh, e);
    end
  endtask

  task automatic test_round_robin();
    int unsigned seq[3] = '{1, 2, 3};
    int unsigned e;
    logic gap;
    int cyc;
    foreach (seq[j]) begin
      exp_q.push_back(seq[j]);
      grant_next(CfgThr, gap, cyc);
      e = exp_q.pop_front();
      n_chk++;
      if (!gap || cyc != 1 || Req !== 1'b1 || ReqCh !== 2'(e)) begin
        n_fail++; $display("FAIL rr_seq[%0d]: gap_low=%b cycles=%0d Req=%b ReqCh=%0d, required gap_low=1 cycles=1 Req=1 ReqCh=%0d", j, gap, cyc, Req, ReqCh, e);
      end
      if (j == 0) begin
        EnWr = 4'b0001;
        repeat (32) tick();
        EnWr = '0;
        n_chk++;
        if (occ_of(0) !== 8'd32 || Empty !== 4'hE || Full !== 4'h0) begin
          n_fail++; $display("FAIL rr_fill0: Occ0=%0d Empty=%h Full=%h, required Occ0=32 Empty=e Full=0", occ_of(0), Empty, Full);
        end
      end
    end
    // Threshold 40 only admits ch0 if its 32 in-flight words were retired
    exp_q.push_back(0);
    grant_next(8'd40, gap, cyc);
    e = exp_q.pop_front();
    n_chk++;
    if (!gap || cyc != 1 || Req !== 1'b1 || ReqCh !== 2'(e)) begin
      n_fail++; $display("FAIL rr_wrap: gap_low=%b cycles=%0d Req=%b ReqCh=%0d, required gap_low=1 cycles=1 Req=1 ReqCh=%0d", gap, cyc, Req, ReqCh, e);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned e;
    Reset = 1'b1; Ack = 1'b1; CfgThr = 8'd0;
    tick();
    n_chk++;
    if (Req !== 1'b0 || Occ !== 32'd0 || Empty !== 4'hF || ErrOvf !== 4'h0 || ErrUdf !== 4'h0) begin
      n_fail++; $display("FAIL midreset_state: Req=%b Occ=%h Empty=%h ErrOvf=%h ErrUdf=%h, required Req=0 Occ=0 Empty=f errors 0", Req, Occ, Empty, ErrOvf, ErrUdf);
    end
    Reset = 1'b0; Ack = 1'b0;
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    n_chk++;
    if (Req !== 1'b1 || ReqCh !== 2'(e)) begin
      n_fail++; $display("FAIL midreset_nogrant: Req=%b ReqCh=%0d, required Req=1 ReqCh=%0d", Req, ReqCh, e);
    end
  endtask

  task automatic test_overflow();
    EnWr = 4'b0100;
    repeat (128) tick();
    n_chk++;
    if (occ_of(2) !== 8'd128 || Full !== 4'b0100 || ErrOvf !== 4'h0) begin
      n_fail++; $display("FAIL ovf_fill: Occ2=%0d Full=%h ErrOvf=%h, required Occ2=128 Full=4 ErrOvf=0", occ_of(2), Full, ErrOvf);
    end
    tick();
    EnWr = '0;
    n_chk++;
    if (occ_of(2) !== 8'd128 || ErrOvf !== 4'b0100) begin
      n_fail++; $display("FAIL ovf_drop: Occ2=%0d ErrOvf=%h, required Occ2=128 ErrOvf=4", occ_of(2), ErrOvf);
    end
    EnWr = 4'b0100; EnRd = 4'b0100;
    tick();
    EnWr = '0; EnRd = '0;
    n_chk++;
    if (occ_of(2) !== 8'd128 || ErrOvf !== 4'b0100 || ErrUdf !== 4'h0 || Full !== 4'b0100) begin
      n_fail++; $display("FAIL ovf_wrrd_full: Occ2=%0d ErrOvf=%h ErrUdf=%h Full=%h, required Occ2=128 ErrOvf=4 ErrUdf=0 Full=4", occ_of(2), ErrOvf, ErrUdf, Full);
    end
    EnRd = 4'b0100;
    tick();
    EnRd = '0;
    n_chk++;
    if (occ_of(2) !== 8'd127 || Full !== 4'h0 || ErrOvf !== 4'b0100) begin
      n_fail++; $display("FAIL ovf_sticky: Occ2=%0d Full=%h ErrOvf=%h, required Occ2=127 Full=0 ErrOvf=4", occ_of(2), Full, ErrOvf);
    end
  endtask

  task automatic test_underflow();
    EnRd = 4'b1000;
    tick();
    EnRd = '0;
    n_chk++;
    if (ErrUdf !== 4'b1000 || occ_of(3) !== 8'd0 || Empty[3] !== 1'b1) begin
      n_fail++; $display("FAIL udf_drop: ErrUdf=%h Occ3=%0d Empty3=%b, required ErrUdf=8 Occ3=0 Empty3=1", ErrUdf, occ_of(3), Empty[3]);
    end
    EnWr = 4'b1000; EnRd = 4'b1000;
    tick();
    EnWr = '0; EnRd = '0;
    n_chk++;
    if (occ_of(3) !== 8'd1 || Empty[3] !== 1'b0 || ErrOvf[3] !== 1'b0 || ErrUdf !== 4'b1000) begin
      n_fail++; $display("FAIL udf_wrrd_empty: Occ3=%0d Empty3=%b ErrOvf3=%b ErrUdf=%h, required Occ3=1 Empty3=0 ErrOvf3=0 ErrUdf=8", occ_of(3), Empty[3], ErrOvf[3], ErrUdf);
    end
  endtask

  task automatic test_threshold();
    int unsigned seq_a[3] = '{2, 3, 1};
    int unsigned seq_b[3] = '{2, 3, 0};
    int unsigned e;
    logic gap;
    int cyc;
    Reset = 1'b1; CfgThr = 8'd120;
    tick();
    Reset = 1'b0;
    n_chk++;
    if (ErrOvf !== 4'h0 || ErrUdf !== 4'h0 || Occ !== 32'd0) begin
      n_fail++; $display("FAIL thr_reset: ErrOvf=%h ErrUdf=%h Occ=%h, required all 0", ErrOvf, ErrUdf, Occ);
    end
    exp_q.push_back(0);
    tick();
    exp_q.push_back(1);
    grant_next(CfgThr, gap, cyc);
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_chk++;
    if (cyc != 1 || Req !== 1'b1 || ReqCh !== 2'(e)) begin
      n_fail++; $display("FAIL thr_ch1: cycles=%0d Req=%b ReqCh=%0d, required cycles=1 Req=1 ReqCh=%0d", cyc, Req, ReqCh, e);
    end
    EnWr = 4'b0001;
    repeat (100) tick();
    EnWr = '0;
    n_chk++;
    if (occ_of(0) !== 8'd100) begin
      n_fail++; $display("FAIL thr_fill0: Occ0=%0d, required 100", occ_of(0));
    end
    // Occ0=100 with no words in flight: 100+32 exceeds the bank, ch0 skipped
    foreach (seq_a[j]) begin
      exp_q.push_back(seq_a[j]);
      grant_next(CfgThr, gap, cyc);
      e = exp_q.pop_front();
      n_chk++;
      if (!gap || cyc != 1 || Req !== 1'b1 || ReqCh !== 2'(e)) begin
        n_fail++; $display("FAIL thr_skip[%0d]: gap_low=%b cycles=%0d Req=%b ReqCh=%0d, required gap_low=1 cycles=1 Req=1 ReqCh=%0d", j, gap, cyc, Req, ReqCh, e);
      end
    end
    EnRd = 4'b0001;
    repeat (4) tick();
    EnRd = '0;
    n_chk++;
    if (occ_of(0) !== 8'd96) begin
      n_fail++; $display("FAIL thr_drain0: Occ0=%0d, required 96", occ_of(0));
    end
    // 96+32 fits exactly, so ch0 becomes eligible again
    foreach (seq_b[j]) begin
      exp_q.push_back(seq_b[j]);
      grant_next(CfgThr, gap, cyc);
      e = exp_q.pop_front();
      n_chk++;
      if (!gap || cyc != 1 || Req !== 1'b1 || ReqCh !== 2'(e)) begin
        n_fail++; $display("FAIL thr_admit[%0d]: gap_low=%b cycles=%0d Req=%b ReqCh=%0d, required gap_low=1 cycles=1 Req=1 ReqCh=%0d", j, gap, cyc, Req, ReqCh, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_mid();
    test_overflow();
    test_underflow();
    test_threshold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
